// File: rtl/pc_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer and the memories.
// Handshake: a *_req stays high until the matching *_ack is seen with it in the same cycle; that cycle completes the transfer.
interface pc_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic ir_load;
  logic dmem_req;
  logic dmem_ack;

  modport master (
    output imem_req,
    output ir_load,
    output dmem_req,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  ir_load,
    input  dmem_req,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the unpipelined core.
// Owns the PC register controls, computes the next PC and counts retired instructions.
module pc_sequencer #(
  parameter int unsigned        ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  pc_sequencer_if.master    mem,
  input  logic [ADDR_W-1:0] pc_q,
  input  logic              is_jump,
  input  logic              is_branch,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_halt,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc_in,
  output logic              pc_en,
  output logic              pc_jump,
  output logic              pc_branch,
  output logic              halted,
  output logic [2:0]        state,
  output logic [31:0]       retired
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [ADDR_W-1:0] pc_seq;

  assign state  = state_q;
  assign pc_seq = pc_q + WORD;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = mem.imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_halt)                   state_d = S_HALT;
        else if (is_jump || is_branch) state_d = S_FETCH;
        else if (is_load || is_store)  state_d = S_MEM;
        else                           state_d = S_WB;
      end
      S_MEM: begin
        if (!mem.dmem_ack) state_d = S_MEM;
        else if (is_load)  state_d = S_WB;
        else               state_d = S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    mem.imem_req  = 1'b0;
    mem.ir_load   = 1'b0;
    mem.dmem_req  = 1'b0;
    rf_we         = 1'b0;
    pc_in         = '0;
    pc_en         = 1'b0;
    pc_jump       = 1'b0;
    pc_branch     = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_INIT: begin
        pc_in   = RESET_VECTOR;
        pc_en   = 1'b1;
        pc_jump = 1'b1;
      end
      S_FETCH: begin
        mem.imem_req = 1'b1;
        // An instruction arriving in a reset cycle is discarded, not latched.
        mem.ir_load  = mem.imem_ack && !Rst;
      end
      S_EXEC: begin
        if (is_halt) begin
          pc_en = 1'b0;
        end else if (is_jump) begin
          pc_in   = jump_target;
          pc_en   = 1'b1;
          pc_jump = 1'b1;
        end else if (is_branch) begin
          pc_en     = 1'b1;
          pc_branch = branch_taken;
          pc_in     = branch_taken ? pc_seq + (branch_offset << 2) : pc_seq;
        end
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        if (mem.dmem_ack && !is_load) begin
          pc_in = pc_seq;
          pc_en = 1'b1;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_in = pc_seq;
        pc_en = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  // Every PC load outside INIT marks the end of one instruction.
  always_ff @(posedge Clk) begin
    if (Rst)                              retired <= '0;
    else if (pc_en && state_q != S_INIT)  retired <= retired + 32'd1;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM for the unpipelined processor.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Is the only block that drives the program counter register's data input, enable, Jump and Branch controls, and it computes the next-PC value.
- Handshakes with instruction and data memory and counts retired instructions.

Parameters:
- ADDR_W, 32: PC and address width.
- RESET_VECTOR, 32'h00000000: PC value loaded after reset.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- pc_q  input  ADDR_W  current PC from the PC register.
- imem_req  output  1  instruction fetch request.
- imem_ack  input  1  instruction available on the instruction bus this cycle.
- ir_load  output  1  load the instruction register.
- is_jump, is_branch, is_load, is_store, is_halt  input  1 each  decode flags, valid in DECODE/EXEC/MEM/WB.
- branch_taken  input  1  branch condition from the ALU, valid in EXEC.
- jump_target  input  ADDR_W  absolute jump address.
- branch_offset  input  ADDR_W  sign-extended word offset.
- dmem_req  output  1  data memory request.
- dmem_ack  input  1  data access complete.
- rf_we  output  1  register-file write enable.
- pc_in  output  ADDR_W  next-PC value to the PC register.
- pc_en  output  1  PC register load enable.
- pc_jump  output  1  PC register Jump control.
- pc_branch  output  1  PC register Branch control.
- halted  output  1  processor halted.
- state  output  3  current FSM state (debug).
- retired  output  32  retired-instruction counter.

Behaviour:
- State encoding: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; codes 7 and above go to INIT.
- Rst=1 at any edge, including mid-instruction:
  - state<=INIT, retired<=0.
  - Outputs take the INIT values next cycle.
  - Requests drop at that edge; pending acks are ignored.
- Outputs are combinational from state and inputs; every output is 0 unless listed for the current state. pc_in=0 when pc_en=0.
- INIT: pc_in=RESET_VECTOR, pc_en=1, pc_jump=1, then FETCH. Does not count as retired.
- FETCH:
  - imem_req=1.
  - If imem_ack: ir_load=1, then DECODE. Otherwise stay, with no timeout.
- DECODE: one cycle, then EXEC.
- EXEC, resolved in priority order is_halt > is_jump > is_branch > (is_load|is_store) > ALU:
  - halt: next state HALT, no PC load.
  - jump: pc_in=jump_target, pc_en=1, pc_jump=1, then FETCH.
  - branch taken: pc_in=pc_q+4+(branch_offset<<2), pc_en=1, pc_branch=1, then FETCH.
  - branch not taken: pc_in=pc_q+4, pc_en=1, pc_branch=0, then FETCH.
  - load/store: next state MEM.
  - ALU: next state WB.
- MEM:
  - dmem_req=1 until dmem_ack.
  - On ack with is_load: next state WB.
  - On ack with store: pc_in=pc_q+4, pc_en=1, then FETCH.
- WB: rf_we=1, pc_in=pc_q+4, pc_en=1, then FETCH.
- HALT: halted=1, all other controls 0. Sticky until Rst.
- Arithmetic: ADDR_W-bit, modulo 2^ADDR_W. 32'hFFFFFFFC+4 wraps to 0. Offset shift discards the upper bits.
- retired increments by 1 on every pc_en cycle except INIT, and wraps at 2^32.
- Ack in a non-waiting state (imem_ack outside FETCH, dmem_ack outside MEM) is ignored.
- pc_jump and pc_branch are never both 1.
- Latency with a same-cycle ack, in cycles:
  - ALU: 4.
  - Jump or branch: 3.
  - Load: 5.
  - Store: 4.

Test Plan:
- Reset: Rst=1 for 2 cycles, then 0 → first cycle after release shows state=INIT, pc_en=1, pc_jump=1, pc_in=0; next cycle imem_req=1; retired=0.
- ALU sequence: pc_q=32'h10, immediate acks → states 1,2,3,5. WB shows rf_we=1, pc_in=32'h14. retired=1 afterwards.
- Branch taken and not taken: pc_q=32'h20, offset=32'hFFFFFFFE, taken=1 → pc_in=32'h1C, pc_branch=1. With taken=0 → pc_in=32'h24, pc_branch=0.
- Jump priority: is_jump=is_branch=1, jump_target=32'h400 → pc_jump=1, pc_branch=0, pc_in=32'h400. Adding is_halt=1 → HALT with no pc_en; halted stays 1 for 10 cycles.
- Memory stalls: load with dmem_ack delayed 3 cycles → dmem_req held for 4 cycles, then WB with rf_we=1. Store with pc_q=32'hFFFFFFFC → pc_in=0.
- Reset mid-fetch: Rst asserted in FETCH with imem_ack=1 → no ir_load, INIT next cycle, retired=0.
